// File: rtl/csa_tree_16to2.sv
// 16-operand carry-save reduction tree with registered outputs.
// The sum and carry words and the final carry-propagate sum are all registered together.
module csa_tree_16to2 (
  input  logic        clk,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [63:0] augends [15:0],
  input  logic        cin,
  output logic [63:0] reduced1,
  output logic [63:0] reduced2,
  output logic [63:0] sum,
  output logic        out_valid
);

  logic [63:0] l0 [16];
  logic [63:0] l1 [11];
  logic [63:0] l2 [8];
  logic [63:0] l3 [6];
  logic [63:0] l4 [4];
  logic [63:0] l5 [3];
  logic [63:0] l6 [2];
  logic [63:0] cpa;

  function automatic logic [63:0] fa_s(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [63:0] c
  );
    return a ^ b ^ c;
  endfunction

  // Majority carry, shifted left one place; bit 64 falls off.
  function automatic logic [63:0] fa_c(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [63:0] c
  );
    logic [63:0] m;
    m = (a & b) | (a & c) | (b & c);
    return {m[62:0], 1'b0};
  endfunction

  // 64-bit adder from 4-bit lookahead groups; carry-out dropped.
  function automatic logic [63:0] cla64(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic        ci
  );
    logic [63:0] g;
    logic [63:0] p;
    logic [63:0] c;
    logic [3:0]  gg;
    logic [3:0]  pp;
    logic        gc;
    g  = a & b;
    p  = a ^ b;
    c  = '0;
    gc = ci;
    for (int j = 0; j < 16; j++) begin
      gg = g[4*j +: 4];
      pp = p[4*j +: 4];
      c[4*j]   = gc;
      c[4*j+1] = gg[0] | (pp[0] & gc);
      c[4*j+2] = gg[1] | (pp[1] & gg[0])
               | (pp[1] & pp[0] & gc);
      c[4*j+3] = gg[2] | (pp[2] & gg[1])
               | (pp[2] & pp[1] & gg[0])
               | (pp[2] & pp[1] & pp[0] & gc);
      gc = gg[3] | (pp[3] & gg[2])
         | (pp[3] & pp[2] & gg[1])
         | (pp[3] & pp[2] & pp[1] & gg[0])
         | (pp[3] & pp[2] & pp[1] & pp[0] & gc);
    end
    return p ^ c;
  endfunction

  // Six 3:2 levels: 16->11->8->6->4->3->2, leftovers pass through.
  always_comb begin
    for (int i = 0; i < 16; i++) l0[i] = augends[i];
    for (int i = 0; i < 5; i++) begin
      l1[2*i]   = fa_s(l0[3*i], l0[3*i+1], l0[3*i+2]);
      l1[2*i+1] = fa_c(l0[3*i], l0[3*i+1], l0[3*i+2]);
    end
    l1[10] = l0[15];
    for (int i = 0; i < 3; i++) begin
      l2[2*i]   = fa_s(l1[3*i], l1[3*i+1], l1[3*i+2]);
      l2[2*i+1] = fa_c(l1[3*i], l1[3*i+1], l1[3*i+2]);
    end
    l2[6] = l1[9];
    l2[7] = l1[10];
    for (int i = 0; i < 2; i++) begin
      l3[2*i]   = fa_s(l2[3*i], l2[3*i+1], l2[3*i+2]);
      l3[2*i+1] = fa_c(l2[3*i], l2[3*i+1], l2[3*i+2]);
    end
    l3[4] = l2[6];
    l3[5] = l2[7];
    for (int i = 0; i < 2; i++) begin
      l4[2*i]   = fa_s(l3[3*i], l3[3*i+1], l3[3*i+2]);
      l4[2*i+1] = fa_c(l3[3*i], l3[3*i+1], l3[3*i+2]);
    end
    l5[0] = fa_s(l4[0], l4[1], l4[2]);
    l5[1] = fa_c(l4[0], l4[1], l4[2]);
    l5[2] = l4[3];
    l6[0] = fa_s(l5[0], l5[1], l5[2]);
    l6[1] = fa_c(l5[0], l5[1], l5[2]);
    cpa   = cla64(l6[0], l6[1], cin);
  end

  // Output registers: clear wins, data hold when no valid input.
  always_ff @(posedge clk) begin
    if (clear) begin
      reduced1  <= '0;
      reduced2  <= '0;
      sum       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        reduced1 <= l6[0];
        reduced2 <= l6[1];
        sum      <= cpa;
      end
    end
  end

endmodule

// File: tb/tb_csa_tree_16to2.sv
// Self-checking bench for csa_tree_16to2.
// Directed cases then random traffic against an arithmetic model.
module tb_csa_tree_16to2;

  logic        clk;
  logic        clear;
  logic        in_valid;
  logic [63:0] augends [15:0];
  logic        cin;
  logic [63:0] reduced1;
  logic [63:0] reduced2;
  logic [63:0] sum;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_tot;
  logic [63:0] m_sum;
  logic        m_vld;

  csa_tree_16to2 dut (
    .clk       (clk),
    .clear     (clear),
    .in_valid  (in_valid),
    .augends   (augends),
    .cin       (cin),
    .reduced1  (reduced1),
    .reduced2  (reduced2),
    .sum       (sum),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic zero_all();
    for (int i = 0; i < 16; i++) augends[i] = '0;
  endtask

  // Model: plain modular sum of the operands, updated on each edge.
  task automatic tick();
    logic [63:0] t;
    t = '0;
    for (int i = 0; i < 16; i++) t = t + augends[i];
    if (clear) begin
      m_tot = '0;
      m_sum = '0;
      m_vld = 1'b0;
    end else begin
      m_vld = in_valid;
      if (in_valid) begin
        m_tot = t;
        m_sum = t + 64'(cin);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".vld"}, 64'(out_valid), 64'(m_vld));
    chk({tag, ".rr"}, reduced1 + reduced2, m_tot);
    chk({tag, ".sum"}, sum, m_sum);
  endtask

  task automatic apply(input string tag,
                       input logic [63:0] want);
    tick();
    chk_all(tag);
    chk({tag, ".const"}, sum, want);
  endtask

  initial begin
    longint mm;
    m_tot = '0;
    m_sum = '0;
    m_vld = 1'b0;
    clear = 1'b1;
    in_valid = 1'b0;
    cin = 1'b0;
    zero_all();
    @(negedge clk);
    tick();
    chk("rst.r1", reduced1, 64'd0);
    chk("rst.r2", reduced2, 64'd0);
    chk("rst.sum", sum, 64'd0);
    chk("rst.vld", 64'(out_valid), 64'd0);

    clear = 1'b0;
    in_valid = 1'b1;
    zero_all();
    apply("zero", 64'd0);

    for (int i = 0; i < 16; i++) augends[i] = 64'(i);
    apply("ramp", 64'd120);
    cin = 1'b1;
    apply("ramp_cin", 64'd121);
    cin = 1'b0;

    for (int i = 0; i < 16; i++) augends[i] = '1;
    apply("all_ones", 64'hFFFF_FFFF_FFFF_FFF0);

    mm = -15;
    zero_all();
    augends[3]  = 64'(-2 * mm);
    augends[8]  = 64'((-mm) <<< 2);
    augends[14] = 64'(mm <<< 4);
    apply("booth_neg", 64'hFFFF_FFFF_FFFF_FF6A);
    mm = 15;
    augends[3]  = 64'(-2 * mm);
    augends[8]  = 64'((-mm) <<< 2);
    augends[14] = 64'(mm <<< 4);
    apply("booth_pos", 64'd150);

    zero_all();
    augends[0] = '1;
    augends[1] = 64'd1;
    apply("wrap", 64'd0);

    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) augends[i] = 64'(i * 7 + 1);
    apply("hold", 64'd0);

    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++)
        augends[i] = 64'((k + 1) * 100 + i);
      apply($sformatf("b2b%0d", k),
            64'((k + 1) * 1600 + 120));
    end

    clear = 1'b1;
    apply("mid_clear", 64'd0);
    chk("mid_clear.r1", reduced1, 64'd0);
    clear = 1'b0;
    for (int i = 0; i < 16; i++) augends[i] = 64'd2;
    apply("post_clear", 64'd32);

    for (int n = 0; n < 10000; n++) begin
      in_valid = ($urandom_range(3) != 0);
      cin = 1'($urandom);
      for (int i = 0; i < 16; i++) begin
        case ($urandom_range(7))
          0: augends[i] = '1;
          1: augends[i] = 64'h8000_0000_0000_0000;
          default: augends[i] = {$urandom, $urandom};
        endcase
      end
      tick();
      chk_all("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
